// File: rtl/panel_pkg.sv
// Shared encodings for the front-panel input controller.
// The mode output carries the FSM state directly, so the state codes equal the mode codes.
package panel_pkg;

    localparam logic [1:0] MODE_STOP = 2'd0;
    localparam logic [1:0] MODE_SLOW = 2'd1;
    localparam logic [1:0] MODE_FAST = 2'd2;

    localparam logic [1:0] ST_STOP = MODE_STOP;
    localparam logic [1:0] ST_SLOW = MODE_SLOW;
    localparam logic [1:0] ST_FAST = MODE_FAST;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchroniser, optional inversion, stable-cycle debounce counter
// and registered press/release pulses.
module debounce_ch #(
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned DEB_CYCLES = 120000
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             s;

    assign s = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            level_d = s;
            press_d = s;
            rel_d   = ~s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/panel_input_ctrl.sv
// Front-panel input controller: debounced buttons plus the STOP/RUN_SLOW/RUN_FAST FSM that
// produces a one-cycle CPU clock enable. Reset is expected to be released synchronously.
module panel_input_ctrl
    import panel_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned DEB_CYCLES = 120000,
    parameter int unsigned SLOW_DIV   = 1200000,
    parameter int unsigned FAST_DIV   = 12,
    parameter int unsigned STEP_CH    = 0,
    parameter int unsigned RUN_CH     = 1,
    parameter int unsigned FAST_CH    = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    input  logic            halt,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic            cpu_en,
    output logic [1:0]      mode
);

    localparam int unsigned DIV_W = $clog2(SLOW_DIV);
    localparam logic [DIV_W-1:0] SLOW_MAX = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_MAX = DIV_W'(FAST_DIV - 1);

    for (genvar g = 0; g < N_CH; g++) begin : gen_ch
        debounce_ch #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clock         (clock),
            .reset         (reset),
            .pin           (btn_in[g]),
            .level         (btn_level[g]),
            .press_pulse   (btn_press[g]),
            .release_pulse (btn_release[g])
        );
    end

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, div_max;
    logic             en_q, en_d;
    logic             step_p, run_p, fast_p;

    assign step_p  = btn_press[STEP_CH];
    assign run_p   = btn_press[RUN_CH];
    assign fast_p  = btn_press[FAST_CH];
    assign div_max = (state_q == ST_FAST) ? FAST_MAX : SLOW_MAX;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        en_d    = 1'b0;
        if (halt) begin
            state_d = ST_STOP;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (run_p)       state_d = ST_SLOW;
                    else if (fast_p) state_d = ST_FAST;
                    else if (step_p) en_d    = 1'b1;
                end
                ST_SLOW: begin
                    if (run_p)       state_d = ST_STOP;
                    else if (fast_p) state_d = ST_FAST;
                end
                ST_FAST: begin
                    if (run_p || fast_p) state_d = ST_STOP;
                end
                default: state_d = ST_STOP;
            endcase
        end
        // Any state entry restarts the divider so the first enable lands DIV cycles later.
        if (state_d != state_q || state_d == ST_STOP) begin
            div_d = '0;
        end else if (div_q == div_max) begin
            div_d = '0;
            en_d  = 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_STOP;
            div_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            en_q    <= en_d;
        end
    end

    assign cpu_en = en_q;
    assign mode   = state_q;

endmodule

// File: tb/tb_panel_input_ctrl.sv
// Directed and randomized bench for panel_input_ctrl against a cycle-level behavioural model.
module tb_panel_input_ctrl;

    localparam int DEB  = 4;
    localparam int SDIV = 8;
    localparam int FDIV = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       halt;
    logic [3:0] btn_in;
    logic [3:0] btn_level, btn_press, btn_release;
    logic       cpu_en;
    logic [1:0] mode;

    panel_input_ctrl #(
        .N_CH       (4),
        .ACTIVE_LOW (1),
        .DEB_CYCLES (DEB),
        .SLOW_DIV   (SDIV),
        .FAST_DIV   (FDIV),
        .STEP_CH    (0),
        .RUN_CH     (1),
        .FAST_CH    (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_in      (btn_in),
        .halt        (halt),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .cpu_en      (cpu_en),
        .mode        (mode)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_en, n_press0, n_rel0, n_press3;

    // Model: pressed-samples history (sample seen by a debouncer lags the pin by two edges).
    bit [3:0] hist[$];
    bit [3:0] m_level, m_press, m_rel;
    bit       m_en;
    int       m_mode, m_since;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_level = '0; m_press = '0; m_rel = '0; m_en = 0;
        m_mode = 0; m_since = 0;
        hist.delete();
        // Synchroniser flops reset to 0, which reads as pressed for active-low pins.
        hist.push_back(4'hF);
        hist.push_back(4'hF);
    endtask

    task automatic model_edge();
        int nm;
        bit flip;
        bit [3:0] nl, np, nr;
        nm = m_mode;
        m_en = 0;
        if (halt) nm = 0;
        else if (m_mode == 0) begin
            if (m_press[1]) nm = 1;
            else if (m_press[2]) nm = 2;
            else if (m_press[0]) m_en = 1;
        end else if (m_mode == 1) begin
            if (m_press[1]) nm = 0;
            else if (m_press[2]) nm = 2;
        end else begin
            if (m_press[1] || m_press[2]) nm = 0;
        end
        if (nm != m_mode) m_since = 0;
        else if (nm != 0) begin
            m_since++;
            m_en = (m_since % ((nm == 1) ? SDIV : FDIV)) == 0;
        end
        m_mode = nm;

        hist.push_back(~btn_in);
        if (hist.size() > DEB + 2) hist.delete(0);
        nl = m_level; np = '0; nr = '0;
        for (int c = 0; c < 4; c++) begin
            flip = (hist.size() == DEB + 2);
            for (int i = 0; i < DEB; i++) if (hist[i][c] == m_level[c]) flip = 0;
            if (flip) begin
                nl[c] = ~m_level[c];
                np[c] = ~m_level[c];
                nr[c] = m_level[c];
            end
        end
        m_level = nl; m_press = np; m_rel = nr;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (reset) model_reset();
        else model_edge();
        chk("level", btn_level, m_level);
        chk("press", btn_press, m_press);
        chk("release", btn_release, m_rel);
        chk("cpu_en", cpu_en, m_en);
        chk("mode", mode, m_mode);
        if (cpu_en === 1'b1) n_en++;
        if (btn_press[0] === 1'b1) n_press0++;
        if (btn_release[0] === 1'b1) n_rel0++;
        if (btn_press[3] === 1'b1) n_press3++;
    endtask

    task automatic wait_mode(input int m, output int c);
        int k = 0;
        while (mode !== m[1:0] && k < 40) begin step(); k++; end
        chk("wait_mode", mode, m);
        c = cyc;
    endtask

    task automatic wait_en(output int c);
        int k = 0;
        do begin step(); k++; end while (cpu_en !== 1'b1 && k < 40);
        chk("wait_en", cpu_en, 1);
        c = cyc;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_level"}, btn_level, 0);
        chk({tag, "_press"}, btn_press, 0);
        chk({tag, "_release"}, btn_release, 0);
        chk({tag, "_en"}, cpu_en, 0);
        chk({tag, "_mode"}, mode, 0);
    endtask

    initial begin
        int t0, t1, t2, k;
        reset = 1'b1; halt = 1'b0; btn_in = 4'hF;
        model_reset();
        #1;
        // 1: reset state, pins toggled under reset
        chk_zero("rst");
        for (int i = 0; i < 6; i++) begin
            btn_in = 4'($urandom);
            step();
            chk_zero("rst_hold");
        end
        btn_in = 4'hF;
        repeat (2) step();
        reset = 1'b0;
        repeat (8) step();

        // 2: bouncing pin then held
        n_press0 = 0; n_rel0 = 0;
        for (int i = 0; i < 6; i++) begin
            btn_in[0] = ~btn_in[0];
            step(); step();
        end
        btn_in[0] = 1'b0;
        k = 0;
        while (btn_level[0] !== 1'b1 && k < 20) begin step(); k++; end
        chk("t2_latency", k, 6);
        repeat (4) step();
        chk("t2_press_cnt", n_press0, 1);
        chk("t2_rel_cnt", n_rel0, 0);
        btn_in[0] = 1'b1;
        repeat (10) step();

        // 3: single step from STOP
        n_en = 0;
        btn_in[0] = 1'b0;
        k = 0;
        while (btn_press[0] !== 1'b1 && k < 20) begin step(); k++; end
        chk("t3_press_seen", btn_press[0], 1);
        step();
        chk("t3_en_next", cpu_en, 1);
        btn_in[0] = 1'b1;
        repeat (12) step();
        chk("t3_en_cnt", n_en, 1);
        chk("t3_mode", mode, 0);

        // 4: slow run, fast run, stop
        btn_in[1] = 1'b0;
        wait_mode(1, t0);
        btn_in[1] = 1'b1;
        wait_en(t1); chk("t4_slow_first", t1 - t0, SDIV);
        wait_en(t2); chk("t4_slow_period", t2 - t1, SDIV);
        btn_in[2] = 1'b0;
        wait_mode(2, t0);
        btn_in[2] = 1'b1;
        wait_en(t1); chk("t4_fast_first", t1 - t0, FDIV);
        wait_en(t2); chk("t4_fast_period", t2 - t1, FDIV);
        repeat (8) step();
        btn_in[1] = 1'b0;
        wait_mode(0, t0);
        btn_in[1] = 1'b1;
        n_en = 0;
        repeat (20) step();
        chk("t4_stop_no_en", n_en, 0);

        // 5: halt handling and simultaneous presses
        btn_in[2] = 1'b0;
        wait_mode(2, t0);
        btn_in[2] = 1'b1;
        repeat (3) step();
        halt = 1'b1;
        step();
        chk("t5_halt_mode", mode, 0);
        chk("t5_halt_en", cpu_en, 0);
        btn_in[1] = 1'b0;
        repeat (10) step();
        chk("t5_run_ignored", mode, 0);
        btn_in[1] = 1'b1;
        repeat (10) step();
        halt = 1'b0;
        step();
        btn_in[1] = 1'b0; btn_in[2] = 1'b0;
        wait_mode(1, t0);
        btn_in[1] = 1'b1; btn_in[2] = 1'b1;
        repeat (5) step();

        // 6: async reset mid RUN_SLOW (divider at 5)
        reset = 1'b1;
        #1;
        chk_zero("t6_async");
        repeat (3) step();
        reset = 1'b0;
        n_en = 0;
        repeat (20) step();
        chk("t6_no_en", n_en, 0);
        chk("t6_mode", mode, 0);
        // button held through reset release still yields a press
        btn_in[3] = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        n_press3 = 0;
        repeat (10) step();
        chk("t6_held_press", n_press3, 1);
        chk("t6_held_level", btn_level[3], 1);
        btn_in[3] = 1'b1;
        repeat (8) step();
        btn_in[1] = 1'b0;
        wait_mode(1, t0);
        btn_in[1] = 1'b1;
        wait_en(t1);
        chk("t6_first_en", t1 - t0, SDIV);

        // Randomized traffic, every cycle compared against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) btn_in[$urandom_range(0, 3)] ^= 1'b1;
            if (!halt && $urandom_range(0, 60) == 0) halt = 1'b1;
            else if (halt && $urandom_range(0, 4) == 0) halt = 1'b0;
            reset = ($urandom_range(0, 700) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
